// File: rtl/boa_extmem_spiflash_pkg.sv
// rtl/boa_extmem_spiflash_pkg.sv - shared types and constants for the SPI flash ROM responder
package boa_extmem_spiflash_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2,
    DESEL = 2'd3
  } state_t;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam int         SPI_ALEN = 24;

endpackage

// File: rtl/boa_spi_shift_engine.sv
// rtl/boa_spi_shift_engine.sv - mode-0 SPI shifter: 32 bits out (cmd+addr), then 32 bits in
module boa_spi_shift_engine #(
  parameter int clk_div = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] tx_word,
  input  logic        miso,
  output logic        busy,
  output logic        done,
  output logic        sck,
  output logic        mosi,
  output logic [31:0] rx_word
);

  localparam logic [7:0] DIV_LAST = 8'(clk_div - 1);

  logic        active_q, active_d;
  logic [7:0]  div_q, div_d;
  logic [5:0]  bit_q, bit_d;
  logic [31:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      sck_q    <= sck_d;
      mosi_q   <= mosi_d;
    end
  end

  // tx_q shifts in zeros, so mosi falls to 0 by itself once the data phase starts
  always_comb begin
    active_d = active_q;
    div_d    = div_q;
    bit_d    = bit_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    sck_d    = sck_q;
    mosi_d   = mosi_q;
    done     = 1'b0;
    if (!active_q) begin
      if (start) begin
        active_d = 1'b1;
        div_d    = '0;
        bit_d    = '0;
        tx_d     = tx_word;
        sck_d    = 1'b0;
        mosi_d   = tx_word[31];
      end
    end else if (div_q != DIV_LAST) begin
      div_d = div_q + 8'd1;
    end else begin
      div_d = '0;
      if (!sck_q) begin
        sck_d = 1'b1;
        if (bit_q[5]) rx_d = {rx_q[30:0], miso};
      end else begin
        sck_d = 1'b0;
        if (bit_q == 6'd63) begin
          active_d = 1'b0;
          mosi_d   = 1'b0;
          done     = 1'b1;
        end else begin
          bit_d  = bit_q + 6'd1;
          tx_d   = {tx_q[30:0], 1'b0};
          mosi_d = tx_q[30];
        end
      end
    end
  end

  assign busy    = active_q;
  assign sck     = sck_q;
  assign mosi    = mosi_q;
  // first received byte belongs at the lowest address, i.e. rdata[7:0]
  assign rx_word = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};

endmodule

// File: rtl/boa_extmem_spiflash.sv
// rtl/boa_extmem_spiflash.sv - external-ROM bus responder serving word reads from SPI NOR flash
module boa_extmem_spiflash
  import boa_extmem_spiflash_pkg::*;
#(
  parameter int              alen       = 19,
  parameter int              clk_div    = 1,
  parameter logic [23:0]     flash_base = 24'h000000,
  parameter int              cs_high    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            re,
  input  logic [3:0]      we,
  input  logic [alen-1:0] addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic            ready,
  output logic            spi_cs_n,
  output logic            spi_sck,
  output logic            spi_mosi,
  input  logic            spi_miso
);

  state_t        state_q, state_d;
  logic          cs_n_q, cs_n_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [3:0]    desel_q, desel_d;
  logic          start;
  logic          eng_busy, eng_done;
  logic [31:0]   eng_rx;
  logic [SPI_ALEN-1:0] word_addr, flash_addr;
  logic          unused_bus_bits;

  // writes need no action: IDLE already answers ready=!re
  assign unused_bus_bits = ^{we, wdata, addr[1:0]};

  assign word_addr  = SPI_ALEN'({addr[alen-1:2], 2'b00});
  assign flash_addr = word_addr + flash_base;

  boa_spi_shift_engine #(.clk_div(clk_div)) u_engine (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .tx_word ({CMD_READ, flash_addr}),
    .miso    (spi_miso),
    .busy    (eng_busy),
    .done    (eng_done),
    .sck     (spi_sck),
    .mosi    (spi_mosi),
    .rx_word (eng_rx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cs_n_q  <= 1'b1;
      rdata_q <= '0;
      desel_q <= '0;
    end else begin
      state_q <= state_d;
      cs_n_q  <= cs_n_d;
      rdata_q <= rdata_d;
      desel_q <= desel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    desel_d = desel_q;
    case (state_q)
      IDLE:  if (re && !eng_busy) state_d = SHIFT;
      SHIFT: if (eng_done) begin
        state_d = DONE;
        rdata_d = eng_rx;
      end
      DONE: begin
        state_d = DESEL;
        desel_d = '0;
      end
      DESEL: begin
        if (desel_q == 4'(cs_high - 1)) state_d = IDLE;
        else desel_d = desel_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
    cs_n_d = (state_d != SHIFT);
  end

  always_comb begin
    start = 1'b0;
    ready = 1'b0;
    case (state_q)
      IDLE: begin
        ready = !re;
        start = re && !eng_busy;
      end
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign rdata    = rdata_q;
  assign spi_cs_n = cs_n_q;

endmodule

// File: tb/tb_boa_extmem_spiflash.sv
// tb/tb_boa_extmem_spiflash.sv - directed bench with a behavioural SPI NOR flash per instance
module tb_boa_extmem_spiflash;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  re = '0;
  logic [3:0]  we = '0;
  logic [18:0] addr = '0;
  logic [31:0] wdata = 32'hCAFEF00D;
  logic [31:0] rdata [3];
  logic [2:0]  ready;
  logic [2:0]  spi_cs_n, spi_sck, spi_mosi;
  logic [2:0]  spi_miso = '0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  boa_extmem_spiflash #(.alen(19), .clk_div(1), .flash_base(24'h000000), .cs_high(2)) u_a (
    .clk(clk), .rst(rst), .re(re[0]), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata[0]), .ready(ready[0]), .spi_cs_n(spi_cs_n[0]), .spi_sck(spi_sck[0]),
    .spi_mosi(spi_mosi[0]), .spi_miso(spi_miso[0]));

  boa_extmem_spiflash #(.alen(19), .clk_div(3), .flash_base(24'h001000), .cs_high(2)) u_b (
    .clk(clk), .rst(rst), .re(re[1]), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata[1]), .ready(ready[1]), .spi_cs_n(spi_cs_n[1]), .spi_sck(spi_sck[1]),
    .spi_mosi(spi_mosi[1]), .spi_miso(spi_miso[1]));

  boa_extmem_spiflash #(.alen(19), .clk_div(1), .flash_base(24'hFFFFFC), .cs_high(2)) u_c (
    .clk(clk), .rst(rst), .re(re[2]), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata[2]), .ready(ready[2]), .spi_cs_n(spi_cs_n[2]), .spi_sck(spi_sck[2]),
    .spi_mosi(spi_mosi[2]), .spi_miso(spi_miso[2]));

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    case (a)
      24'h000010: flash_byte = 8'h11;
      24'h000011: flash_byte = 8'h22;
      24'h000012: flash_byte = 8'h33;
      24'h000013: flash_byte = 8'h44;
      24'h001010: flash_byte = 8'hDE;
      24'h001011: flash_byte = 8'hAD;
      24'h001012: flash_byte = 8'hBE;
      24'h001013: flash_byte = 8'hEF;
      24'h000000: flash_byte = 8'hA0;
      24'h000001: flash_byte = 8'hB1;
      24'h000002: flash_byte = 8'hC2;
      24'h000003: flash_byte = 8'hD3;
      default:    flash_byte = a[7:0] ^ 8'h5A;
    endcase
  endfunction

  // Flash model: latches 32 bits on sck rise, presents data on sck fall after the address
  int          fl_cnt [3];
  logic [31:0] fl_cmd [3];
  logic [2:0]  fl_sck_prev = '0;

  always @(negedge clk) begin
    logic [7:0] b;
    int         k;
    for (int i = 0; i < 3; i++) begin
      if (spi_cs_n[i]) begin
        fl_cnt[i]      = 0;
        fl_sck_prev[i] = 1'b0;
      end else begin
        if (spi_sck[i] && !fl_sck_prev[i]) begin
          if (fl_cnt[i] < 32) fl_cmd[i] = {fl_cmd[i][30:0], spi_mosi[i]};
          fl_cnt[i]++;
        end else if (!spi_sck[i] && fl_sck_prev[i] && fl_cnt[i] >= 32 && fl_cnt[i] < 64) begin
          k = fl_cnt[i] - 32;
          b = flash_byte(fl_cmd[i][23:0] + 24'(k / 8));
          spi_miso[i] = b[7 - (k % 8)];
        end
        fl_sck_prev[i] = spi_sck[i];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Called at a negedge; leaves re asserted and returns at the negedge of the DONE cycle
  task automatic do_read(input int i, input logic [18:0] a, input int d, input int extra,
                         input logic [31:0] exp_data, input logic [31:0] exp_cmd, input string tag);
    int   cyc, cs_hi, r1, r2;
    logic sp;
    addr  = a;
    re[i] = 1'b1;
    #1;
    if (extra == 0) check({tag, "_rdy_low"}, 32'(ready[i]), 32'd0);
    cyc = 0; cs_hi = 0; r1 = -1; r2 = -1; sp = spi_sck[i];
    do begin
      @(negedge clk);
      cyc++;
      if (spi_cs_n[i]) cs_hi++;
      if (spi_sck[i] && !sp) begin
        if (r1 < 0) r1 = cyc;
        else if (r2 < 0) r2 = cyc;
      end
      sp = spi_sck[i];
    end while (!ready[i] && cyc < 3000);
    check({tag, "_latency"}, cyc, 32'(1 + 128 * d + extra));
    check({tag, "_rdata"}, rdata[i], exp_data);
    check({tag, "_cmd"}, fl_cmd[i], exp_cmd);
    check({tag, "_sck_period"}, 32'(r2 - r1), 32'(2 * d));
    if (extra > 0) check({tag, "_cs_gap_ge2"}, 32'(cs_hi >= 2), 32'd1);
  endtask

  initial begin
    int bad;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cs_n", 32'(spi_cs_n), 32'h7);
    check("rst_sck", 32'(spi_sck), 32'h0);
    check("rst_mosi", 32'(spi_mosi), 32'h0);
    check("rst_rdata", rdata[0], 32'h0);
    check("rst_ready", 32'(ready), 32'h7);

    do_read(0, 19'h10, 1, 0, 32'h44332211, {8'h03, 24'h000010}, "basic");
    re[0] = 1'b0;
    @(negedge clk);

    repeat (4) @(negedge clk);
    we = 4'hF;
    #1;
    check("wr_ready", 32'(ready[0]), 32'd1);
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (spi_cs_n[0] !== 1'b1 || spi_sck[0] !== 1'b0) bad++;
    end
    check("wr_no_spi", bad, 0);
    check("wr_rdata_hold", rdata[0], 32'h44332211);
    we = 4'h0;
    @(negedge clk);

    addr  = 19'h10;
    re[0] = 1'b1;
    repeat (40) @(negedge clk);
    check("mid_cs_low", 32'(spi_cs_n[0]), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_cs_n", 32'(spi_cs_n[0]), 32'd1);
    check("abort_sck", 32'(spi_sck[0]), 32'd0);
    check("abort_rdata", rdata[0], 32'h0);
    rst   = 1'b0;
    re[0] = 1'b0;
    @(negedge clk);
    do_read(0, 19'h10, 1, 0, 32'h44332211, {8'h03, 24'h000010}, "reread");
    re[0] = 1'b0;
    @(negedge clk);

    do_read(1, 19'h13, 3, 0, 32'hEFBEADDE, {8'h03, 24'h001010}, "offset");
    do_read(1, 19'h00, 3, 3, 32'h59585B5A, {8'h03, 24'h001000}, "b2b");
    re[1] = 1'b0;
    @(negedge clk);

    do_read(2, 19'h04, 1, 0, 32'hD3C2B1A0, {8'h03, 24'h000000}, "wrap");
    re[2] = 1'b0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/boa_extmem_spiflash.md
Name: boa_extmem_spiflash

Overview:
- Responder for the external-ROM memory port; replaces the constant-ready stub on the extrom side.
- Serves word reads from a SPI NOR flash using standard READ (0x03), 24-bit address, mode 0, single I/O.
- Acts as initiator on the SPI pins and responder on the flat memory-bus side.
- Writes are acknowledged and discarded; the flash is read-only through this block.

Parameters:
- alen, 19, memory-bus byte-address width; legal range 3..24.
- clk_div, 1, SCK half-period in clk cycles; legal range 1..255.
- flash_base, 24'h000000, offset added to the bus address to form the flash address; wraps modulo 2^24.
- cs_high, 2, minimum cs_n deassert cycles between transactions; legal range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  reset: synchronous, active-high
- re  in  1  read request
- we  in  4  byte write strobes; any nonzero value is a write request
- addr  in  alen  byte address; addr[1:0] ignored
- wdata  in  32  write data, ignored
- rdata  out  32  read data; valid only while ready=1 after an accepted read
- ready  out  1  transaction complete / idle
- spi_cs_n  out  1  flash chip select, active low
- spi_sck  out  1  flash clock, idle low
- spi_mosi  out  1  flash data in
- spi_miso  in  1  flash data out

Behaviour:
- Reset values: cs_n=1, sck=0, mosi=0, rdata=0, state=IDLE. Asserting rst in any state aborts the transaction: next cycle cs_n=1, sck=0, IDLE.
- States and transitions:
  - IDLE: ready = !re. re=1 accepts the read (cycle 0); re takes priority over we. re=0 with we!=0 gives ready=1 in the same cycle with no SPI activity.
  - SHIFT: entered at cycle 1. cs_n=0. 64 bits: 8 command + 24 address + 32 data.
  - DONE: 1 cycle. ready=1, rdata valid.
  - DESEL: cs_n=1 for cs_high cycles, ready=0. Then IDLE.
- Shift word: {8'h03, fa[23:0]}, where fa = ({addr[alen-1:2],2'b00} zero-extended to 24) + flash_base, mod 2^24. Sent MSB first.
- SCK timing, per bit: sck low for clk_div cycles, then high for clk_div cycles.
  - mosi is updated at the start of the low phase.
  - miso is sampled on the clk edge where sck rises (mode 0).
  - Bit 0 is driven at cycle 1.
- Data assembly:
  - Data bits 0..31 are received MSB first within each byte.
  - Byte at fa → rdata[7:0], fa+1 → [15:8], fa+2 → [23:16], fa+3 → [31:24] (little-endian).
  - mosi is don't-care during the data phase; drive 0.
- Latency: DONE at cycle 1 + 128*clk_div after accept (129 for clk_div=1). sck returns low in the DONE cycle.
- rdata holds its last value until the next completed read; it is not cleared by writes.
- The requester must hold re/addr stable until ready=1. addr is latched at accept; later changes are ignored.
- A new request arriving in DONE+1 or DESEL is stalled (ready=0) and accepted on the first IDLE cycle.
- The flash address wraps 24'hFFFFFF → 0 within a word (flash sequential-read semantics).

Decomposition:
- Package boa_extmem_spiflash_pkg: state enum (IDLE, SHIFT, DONE, DESEL), CMD_READ=8'h03, SPI_ALEN=24.
- Sub-module boa_spi_shift_engine:
  - clk_div phase counter, 6-bit bit counter, 32-bit out shift register, 32-bit in shift register with byte reordering.
  - start/busy handshake.
- The top module holds the FSM, address formation and bus-side ready logic.

Test Plan:
- Basic read (clk_div=1): flash model holds 11 22 33 44 at 0x10; re, addr=0x10 → mosi carries 0x03,0x00,0x00,0x10; ready=1 at cycle 129; rdata=0x44332211.
- Unaligned plus offset: flash_base=0x1000, addr=0x13 → flash address 0x001010; data DE AD BE EF → rdata=0xEFBEADDE.
- Write: we=4'hF, re=0 → ready=1 same cycle; cs_n stays 1, sck stays 0 throughout.
- Reset mid-transfer: rst at cycle 40 of a read → cs_n=1 and sck=0 the next cycle; a subsequent read of 0x10 returns 0x44332211 correctly.
- Back-to-back reads with re held high, clk_div=3: cs_n high ≥2 cycles between transactions; each read takes 385 cycles to ready; sck period is 6 clk cycles.
- Wrap at top: flash_base=0xFFFFFC, addr=0x4 → flash address 0x000000; rdata matches flash bytes 0..3.
